// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the iterative shift-add multiplier.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_if.sv
// Request/busy/done handshake between the EX stage (master) and mul_seq (slave).
interface mul_if #(
  parameter int WIDTH = mul_pkg::MUL_WIDTH
);

  logic             cancel;
  logic             mul;
  logic             mul_signed;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output cancel, mul, mul_signed, x, y,
    input  hi, lo, busy, done
  );

  modport slave (
    input  cancel, mul, mul_signed, x, y,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/mul_step.sv
// One radix-2 iteration: conditionally add the multiplicand into the upper half,
// then shift the {acc,mplr} pair right by one.
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mplr,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] mplr_next
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shifted;

  always_comb begin
    sum       = acc + (mplr[0] ? {1'b0, mcand} : '0);
    shifted   = {sum, mplr} >> 1;
    acc_next  = shifted[2*WIDTH:WIDTH];
    mplr_next = shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mul_seq.sv
// Iterative signed/unsigned multiplier for MULT/MULTU with level request handshake.
// Optional early termination on small multipliers via `define MUL_EARLY_OUT_EN.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input logic  div_clk,
  input logic  rst,
  mul_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]         state;
  logic               sx, sy;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   mplr, mcand;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH:0]     acc_nx;
  logic [WIDTH-1:0]   mplr_nx;
  logic               last;
  logic [2*WIDTH-1:0] prod, prod_final;
  logic               start, x_neg, y_neg;

  assign start = (state == ST_IDLE) & bus.mul & ~bus.cancel;
  assign x_neg = bus.mul_signed & bus.x[WIDTH-1];
  assign y_neg = bus.mul_signed & bus.y[WIDTH-1];

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc),
    .mplr      (mplr),
    .mcand     (mcand),
    .acc_next  (acc_nx),
    .mplr_next (mplr_nx)
  );

`ifdef MUL_EARLY_OUT_EN
  // Once the unconsumed multiplier bits are zero, the remaining iterations would
  // only shift, so jump ahead and align the partial product in one step.
  logic [CNT_W:0]   iters_done;
  logic [WIDTH-1:0] rem_mask;
  logic [CNT_W-1:0] shamt;

  always_comb begin
    iters_done = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    rem_mask   = {WIDTH{1'b1}} >> iters_done;
    shamt      = CNT_W'(WIDTH-1) - cnt;
    last       = (cnt == CNT_W'(WIDTH-1)) | ((mplr_nx & rem_mask) == '0);
    prod       = (2*WIDTH)'({acc_nx, mplr_nx} >> shamt);
  end
`else
  always_comb begin
    last = (cnt == CNT_W'(WIDTH-1));
    prod = (2*WIDTH)'({acc_nx, mplr_nx});
  end
`endif

  assign prod_final = (sx ^ sy) ? -prod : prod;

  // Reset beats cancel beats normal sequencing; results land on entry to DONE.
  always_ff @(posedge div_clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sx    <= 1'b0;
      sy    <= 1'b0;
      acc   <= '0;
      mplr  <= '0;
      mcand <= '0;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sx    <= x_neg;
            sy    <= y_neg;
            mcand <= x_neg ? -bus.x : bus.x;
            mplr  <= y_neg ? -bus.y : bus.y;
            acc   <= '0;
            cnt   <= '0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (bus.cancel) begin
            state <= ST_IDLE;
          end else begin
            acc  <= acc_nx;
            mplr <= mplr_nx;
            cnt  <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (last) begin
              {hi_q, lo_q} <= prod_final;
              state        <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state == ST_CALC) | start;
  assign bus.done = (state == ST_DONE);

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: expected products are queued at request time
// and popped when done pulses. Early-out latency tracked with MUL_EARLY_OUT_EN.
module tb_mul_seq;

  localparam int W = 32;

  logic div_clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [63:0] exp_q[$];
  logic [63:0] last_result;

  mul_if #(.WIDTH(W)) bus ();

  mul_seq #(.WIDTH(W)) dut (
    .div_clk (div_clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Posedges from the start edge (inclusive) until done is visible.
  function automatic int exp_latency(input logic [31:0] b, input logic s);
    logic [31:0] mag;
    int n;
    mag = (s & b[31]) ? -b : b;
    n = 1;
    for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
`ifdef MUL_EARLY_OUT_EN
    return n + 1;
`else
    return (n > 0) ? W + 1 : 0;
`endif
  endfunction

  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.x = a;
    bus.y = b;
    bus.mul_signed = s;
    bus.mul = 1'b1;
    exp_q.push_back(ref_mul(a, b, s));
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < budget) begin
      @(posedge div_clk);
      cycles++;
      @(negedge div_clk);
      if (bus.done) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.cancel = 1'b0;
    bus.mul = 1'b0;
    bus.mul_signed = 1'b0;
    bus.x = '0;
    bus.y = '0;
    repeat (3) @(posedge div_clk);
    @(negedge div_clk);
    rst = 1'b0;
    @(negedge div_clk);
    vectors++;
    if ({bus.hi, bus.lo} !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_hilo: got %h, want 0", {bus.hi, bus.lo});
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy: got %b, want 0", bus.busy);
    end
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_done: got %b, want 0", bus.done);
    end
    last_result = '0;
  endtask

  task automatic test_unsigned;
    int cyc;
    bit seen;
    logic [63:0] exp;
    drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    #1;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL unsigned_busy_start: got %b, want 1", bus.busy);
    end
    wait_done(100, cyc, seen);
    bus.mul = 1'b0;
    exp = exp_q.pop_front();
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL unsigned_timeout: got no done, want done");
    end
    vectors++;
    if (cyc !== exp_latency(32'hFFFF_FFFF, 1'b0)) begin
      miscompares++;
      $display("[TB] FAIL unsigned_latency: got %0d, want %0d", cyc, exp_latency(32'hFFFF_FFFF, 1'b0));
    end
    vectors++;
    if ({bus.hi, bus.lo} !== exp) begin
      miscompares++;
      $display("[TB] FAIL unsigned_product: got %h, want %h", {bus.hi, bus.lo}, exp);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL unsigned_busy_done: got %b, want 0", bus.busy);
    end
    last_result = exp;
    @(negedge div_clk);
  endtask

  task automatic test_signed;
    logic [31:0] xs[2];
    logic [31:0] ys[2];
    int cyc;
    bit seen;
    logic [63:0] exp;
    xs[0] = 32'hFFFF_FFFD; ys[0] = 32'd7;
    xs[1] = 32'h8000_0000; ys[1] = 32'h8000_0000;
    for (int i = 0; i < 2; i++) begin
      drive_start(xs[i], ys[i], 1'b1);
      wait_done(100, cyc, seen);
      bus.mul = 1'b0;
      exp = exp_q.pop_front();
      vectors++;
      if (!seen || cyc !== exp_latency(ys[i], 1'b1)) begin
        miscompares++;
        $display("[TB] FAIL signed_latency[%0d]: got %0d (seen %b), want %0d", i, cyc, seen, exp_latency(ys[i], 1'b1));
      end
      vectors++;
      if ({bus.hi, bus.lo} !== exp) begin
        miscompares++;
        $display("[TB] FAIL signed_product[%0d]: got %h, want %h", i, {bus.hi, bus.lo}, exp);
      end
      last_result = exp;
      @(negedge div_clk);
    end
  endtask

  task automatic test_cancel;
    int n_pre;
    int pulses;
    int cyc;
    bit seen;
    logic [63:0] exp;
    drive_start(32'd6, 32'd7, 1'b0);
    n_pre = exp_latency(32'd7, 1'b0) - 1;
    if (n_pre > 10) n_pre = 10;
    repeat (n_pre) @(posedge div_clk);
    @(negedge div_clk);
    bus.cancel = 1'b1;
    bus.mul = 1'b0;
    void'(exp_q.pop_back());
    pulses = 0;
    @(posedge div_clk);
    @(negedge div_clk);
    if (bus.done) pulses++;
    bus.cancel = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cancel_busy: got %b, want 0", bus.busy);
    end
    repeat (40) begin
      @(posedge div_clk);
      @(negedge div_clk);
      if (bus.done) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("[TB] FAIL cancel_no_done: got %0d pulses, want 0", pulses);
    end
    vectors++;
    if ({bus.hi, bus.lo} !== last_result) begin
      miscompares++;
      $display("[TB] FAIL cancel_hold: got %h, want %h", {bus.hi, bus.lo}, last_result);
    end
    drive_start(32'd6, 32'd7, 1'b0);
    wait_done(100, cyc, seen);
    bus.mul = 1'b0;
    exp = exp_q.pop_front();
    vectors++;
    if (!seen || {bus.hi, bus.lo} !== exp) begin
      miscompares++;
      $display("[TB] FAIL cancel_retry: got %h (seen %b), want %h", {bus.hi, bus.lo}, seen, exp);
    end
    last_result = exp;
    @(negedge div_clk);
  endtask

  task automatic test_reset_mid;
    int n_pre;
    drive_start(32'd12345, 32'd678, 1'b0);
    n_pre = exp_latency(32'd678, 1'b0) - 1;
    if (n_pre > 5) n_pre = 5;
    repeat (n_pre) @(posedge div_clk);
    @(negedge div_clk);
    rst = 1'b1;
    bus.mul = 1'b0;
    void'(exp_q.pop_back());
    @(posedge div_clk);
    @(negedge div_clk);
    rst = 1'b0;
    vectors++;
    if ({bus.hi, bus.lo} !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_hilo: got %h, want 0", {bus.hi, bus.lo});
    end
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_flags: got busy %b done %b, want 0 0", bus.busy, bus.done);
    end
    last_result = '0;
    @(negedge div_clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit seen;
    logic [63:0] exp;
    drive_start(32'hDEAD_BEEF, 32'h0001_2345, 1'b1);
    wait_done(100, cyc, seen);
    exp = exp_q.pop_front();
    vectors++;
    if (!seen || {bus.hi, bus.lo} !== exp) begin
      miscompares++;
      $display("[TB] FAIL held_first: got %h (seen %b), want %h", {bus.hi, bus.lo}, seen, exp);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL held_busy_done: got %b, want 0", bus.busy);
    end
    exp_q.push_back(ref_mul(bus.x, bus.y, bus.mul_signed));
    @(posedge div_clk);
    @(negedge div_clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL held_gap: got done %b busy %b, want 0 1", bus.done, bus.busy);
    end
    wait_done(100, cyc, seen);
    bus.mul = 1'b0;
    exp = exp_q.pop_front();
    vectors++;
    if (!seen || cyc !== exp_latency(32'h0001_2345, 1'b1)) begin
      miscompares++;
      $display("[TB] FAIL held_latency: got %0d (seen %b), want %0d", cyc, seen, exp_latency(32'h0001_2345, 1'b1));
    end
    vectors++;
    if ({bus.hi, bus.lo} !== exp) begin
      miscompares++;
      $display("[TB] FAIL held_repeat: got %h, want %h", {bus.hi, bus.lo}, exp);
    end
    last_result = exp;
    @(negedge div_clk);
  endtask

  task automatic test_early_out;
    logic [31:0] xs[2];
    logic [31:0] ys[2];
    int cyc;
    bit seen;
    logic [63:0] exp;
    xs[0] = 32'h0000_1234; ys[0] = 32'd0;
    xs[1] = 32'd9;         ys[1] = 32'd5;
    for (int i = 0; i < 2; i++) begin
      drive_start(xs[i], ys[i], 1'b0);
      wait_done(100, cyc, seen);
      bus.mul = 1'b0;
      exp = exp_q.pop_front();
      vectors++;
      if (!seen || cyc !== exp_latency(ys[i], 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL early_latency[%0d]: got %0d (seen %b), want %0d", i, cyc, seen, exp_latency(ys[i], 1'b0));
      end
      vectors++;
      if ({bus.hi, bus.lo} !== exp) begin
        miscompares++;
        $display("[TB] FAIL early_product[%0d]: got %h, want %h", i, {bus.hi, bus.lo}, exp);
      end
      last_result = exp;
      @(negedge div_clk);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic s;
    int cyc;
    bit seen;
    logic [63:0] exp;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 7 == 1) b = b >> $urandom_range(31, 0);
      if (i % 11 == 2) a = 32'h8000_0000;
      s = 1'($urandom_range(1, 0));
      drive_start(a, b, s);
      @(posedge div_clk);
      #1;
      bus.x = $urandom;
      bus.y = $urandom;
      wait_done(100, cyc, seen);
      cyc++;
      bus.mul = 1'b0;
      exp = exp_q.pop_front();
      vectors++;
      if (!seen || cyc !== exp_latency(b, s)) begin
        miscompares++;
        $display("[TB] FAIL rand_latency[%0d]: got %0d (seen %b), want %0d", i, cyc, seen, exp_latency(b, s));
      end
      vectors++;
      if ({bus.hi, bus.lo} !== exp) begin
        miscompares++;
        $display("[TB] FAIL rand_product[%0d] x=%h y=%h s=%b: got %h, want %h", i, a, b, s, {bus.hi, bus.lo}, exp);
      end
      last_result = exp;
      @(negedge div_clk);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    last_result = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    test_early_out();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative radix-2 shift-add multiplier, the inverse-operation companion of the EX-stage iterative divider, sharing the same level-held request / busy / done handshake. It serves MULT/MULTU. It takes two WIDTH-bit operands, signed or unsigned, and returns a 2·WIDTH-bit product split into hi/lo for the HI/LO register write-back. The EX stage stalls on busy and samples hi/lo on done.

## Interface
- WIDTH, 32: operand width; product is 2·WIDTH.
- div_clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high; clock div_clk.
- cancel  in  1  pipeline flush; aborts the operation in progress.
- mul  in  1  request; level, held high by the EX stage until done.
- mul_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- x  in  WIDTH  multiplicand; sampled only on the start cycle.
- y  in  WIDTH  multiplier; sampled only on the start cycle.
- hi  out  WIDTH  product[2·WIDTH-1:WIDTH]; registered; reset 0.
- lo  out  WIDTH  product[WIDTH-1:0]; registered; reset 0.
- busy  out  1  (state==CALC) | (state==IDLE & mul & ~cancel); reset 0.
- done  out  1  one-cycle pulse, high in state DONE; reset 0.

## Operation
- States: IDLE, CALC, DONE. Reset and cancel force IDLE.
- IDLE with mul=1 and cancel=0:
  - latch sx=mul_signed&x[MSB] and sy=mul_signed&y[MSB];
  - latch mcand=|x| and mplr=|y| (two's-complement negate when the sign is set);
  - acc=0 (WIDTH+1 bits), cnt=0;
  - go to CALC.
- CALC, per cycle:
  - sum = acc + (mplr[0] ? mcand : 0), computed at WIDTH+1 bits;
  - {acc,mplr} <= {sum,mplr} >> 1;
  - cnt++.
  - After the iteration with cnt reaching WIDTH-1 (WIDTH iterations total), go to DONE.
- Entry to DONE:
  - {hi,lo} <= (sx^sy) ? -{acc,mplr} : {acc,mplr}, negated at 2·WIDTH bits.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally, even if mul is still high.
  - The EX stage drops mul in the cycle after done. If mul is still high in IDLE, a new operation starts.
- hi/lo hold their value until the next entry to DONE; they are not cleared at start.
- x and y may change after the start cycle without effect.
- Priority: rst > cancel > normal.
  - cancel in CALC: IDLE next cycle, no done, hi/lo unchanged.
  - cancel in DONE: done still shows this cycle, hi/lo already updated.
  - cancel and mul together in IDLE: no start.
- mul deasserted mid-CALC (protocol violation): the operation completes normally.
- Width rules:
  - The most negative operand is negated to 2^(WIDTH-1), which fits the unsigned WIDTH-bit magnitude.
  - The product of two negatives, 2^62, fits the 64-bit product.

## Timing
- Start edge S = the rising edge that samples mul=1 in IDLE.
- Without the early-out macro: WIDTH iteration edges follow (S+1..S+32); done is high in the cycle after edge S+32.
  - This is 33 cycles from start to done for WIDTH=32.
- busy is high combinationally from the cycle mul rises through the last CALC cycle, and low during the done cycle.
- Back-to-back operations: minimum 1 idle cycle between done and the next start edge.

## Configuration
- MUL_EARLY_OUT_EN defined:
  - CALC exits to DONE as soon as the post-shift mplr upper bits are all zero.
  - The product is aligned with a right shift of {acc,mplr} by the remaining count (WIDTH-1-cnt).
  - Iterations = max(1, msb_index(|y|)+1). Example: y=5 takes 3 iterations, so done comes 4 cycles after the start edge.
  - Results are bit-identical to the macro-off case.
- MUL_EARLY_OUT_EN undefined: fixed WIDTH iterations, no shifter logic.

## Structure
- Package mul_pkg:
  - state enum {IDLE, CALC, DONE};
  - MUL_WIDTH=32 constant;
  - counter width $clog2(MUL_WIDTH) constant.
- Sub-module mul_step: combinational one-iteration add-and-shift.
  - Inputs: acc, mplr, mcand. Outputs: next acc, next mplr.
  - Instantiated once in mul_seq.
- Sign handling and DONE-entry negation stay in mul_seq.

## Test plan
- Unsigned: x=0xFFFFFFFF, y=0xFFFFFFFF, mul_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001; done 33 cycles after start (macro off).
- Signed: x=0xFFFFFFFD (-3), y=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then x=0x80000000, y=0x80000000 -> hi=0x40000000, lo=0.
- Cancel mid-operation: start 6×7, assert cancel at iteration 10 -> no done pulse, hi/lo keep their prior value; a new 6×7 then gives hi=0, lo=42.
- Reset mid-operation: rst at iteration 5 -> next cycle hi=lo=0, busy=0, done=0, state IDLE.
- Held request: mul kept high through done -> exactly one done pulse, new start on the edge after the done cycle, result repeated.
- MUL_EARLY_OUT_EN: y=0 -> done 2 cycles after start, product 0; y=5, x=9 -> lo=45 at 4 cycles. Random 1000 signed/unsigned pairs match the reference model with the macro on and off.
